// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_block memory.
// RAM_PARITY_EN adds one even-parity bit above each stored word.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

`ifdef RAM_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif

  localparam int unsigned MAX_DATA_W = 64;

  // Width of one array word for a given data width.
  function automatic int unsigned word_w(input int unsigned data_w);
    return data_w + PAR_W;
  endfunction

  // Even parity; callers zero-extend narrower data.
  function automatic logic parity(input logic [MAX_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_block_array.sv
// Plain storage: one synchronous write port and one registered read port, no reset.
// Word width is chosen by the parent (includes the parity bit when RAM_PARITY_EN is set).
module ram_array #(
  parameter int unsigned W      = 12,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [W-1:0]      wdata,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata     <= mem[addr];
  end

endmodule

// File: rtl/ram_block.sv
// Single-port RAM with valid/ready requests, 1-cycle read response and a clear engine.
// Define RAM_PARITY_EN to store and check per-word even parity.
module ram_block
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_oor,
  output logic              rsp_perr,
  input  logic              clr_start,
  output logic              clr_busy,
  input  logic              err_inj
);

  localparam int unsigned WORD_W = word_w(DATA_W);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  logic              in_range;
  logic              wr_acc;
  logic              rd_acc;
  logic              arr_we;
  logic              arr_re;
  logic [ADDR_W-1:0] arr_addr;
  logic [WORD_W-1:0] arr_wdata;
  logic [WORD_W-1:0] arr_rdata;
  logic [WORD_W-1:0] wr_word;
  logic              perr_c;

  logic              rsp_valid_q;
  logic              rsp_oor_q;
  logic              rsp_sel_q;

  // State and clear pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
        else clr_ptr_d = clr_ptr_q + ADDR_W'(1);
      end
      RUN: begin
        if (clr_start) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  assign req_ready = (state_q == RUN);
  assign clr_busy  = (state_q == CLEAR);

  assign in_range = (32'(req_addr) < 32'(DEPTH));
  assign wr_acc   = req_valid & req_ready & req_we;
  assign rd_acc   = req_valid & req_ready & ~req_we;

`ifdef RAM_PARITY_EN
  assign wr_word = {parity(MAX_DATA_W'(req_wdata)) ^ err_inj, req_wdata};
  assign perr_c  = parity(MAX_DATA_W'(arr_rdata[DATA_W-1:0])) != arr_rdata[DATA_W];
`else
  logic unused_err_inj;
  assign unused_err_inj = err_inj;
  assign wr_word        = req_wdata;
  assign perr_c         = 1'b0;
`endif

  // Clear engine owns the port while busy; out-of-range requests never reach the array.
  assign arr_we    = clr_busy | (wr_acc & in_range);
  assign arr_re    = rd_acc & in_range;
  assign arr_addr  = clr_busy ? clr_ptr_q : req_addr;
  assign arr_wdata = clr_busy ? '0 : wr_word;

  ram_array #(
    .W      (WORD_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // rsp_sel_q picks array data (last in-range read) or zero (out-of-range or reset)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_oor_q   <= 1'b0;
      rsp_sel_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rd_acc;
      rsp_oor_q   <= rd_acc & ~in_range;
      if (rd_acc) rsp_sel_q <= in_range;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_oor   = rsp_oor_q;
  assign rsp_rdata = rsp_sel_q ? arr_rdata[DATA_W-1:0] : '0;
  assign rsp_perr  = rsp_valid_q & rsp_sel_q & perr_c;

endmodule

// File: tb/tb_ram_block.sv
// Directed bench for ram_block: a 1024-word and a 1000-word instance share all inputs.
// Parity expectations follow RAM_PARITY_EN.
module tb_ram_block;

`ifdef RAM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_we, clr_start, err_inj;
  logic [9:0]  req_addr;
  logic [11:0] req_wdata;

  logic        ready_a, valid_a, oor_a, perr_a, busy_a;
  logic [11:0] rdata_a;
  logic        ready_b, valid_b, oor_b, perr_b, busy_b;
  logic [11:0] rdata_b;

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  ram_block #(.DATA_W(12), .ADDR_W(10), .DEPTH(1024)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(valid_a), .rsp_rdata(rdata_a), .rsp_oor(oor_a), .rsp_perr(perr_a),
    .clr_start(clr_start), .clr_busy(busy_a), .err_inj(err_inj)
  );

  ram_block #(.DATA_W(12), .ADDR_W(10), .DEPTH(1000)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(valid_b), .rsp_rdata(rdata_b), .rsp_oor(oor_b), .rsp_perr(perr_b),
    .clr_start(clr_start), .clr_busy(busy_b), .err_inj(err_inj)
  );

  typedef struct packed {
    logic        we;
    logic [9:0]  addr;
    logic [11:0] wdata;
    logic        err;
    logic [11:0] exp_a;
    logic        oor_a;
    logic [11:0] exp_b;
    logic        oor_b;
    logic        perr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit we, int addr, int wdata, bit err,
                              int ea, bit oa, int eb, bit ob, bit ep);
    vec_t v;
    v.we = we; v.addr = 10'(addr); v.wdata = 12'(wdata); v.err = err;
    v.exp_a = 12'(ea); v.oor_a = oa; v.exp_b = 12'(eb); v.oor_b = ob; v.perr = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " ready_a"}, 32'(ready_a), 0);
    chk({tag, " busy_a"},  32'(busy_a), 1);
    chk({tag, " valid_a"}, 32'(valid_a), 0);
    chk({tag, " rdata_a"}, 32'(rdata_a), 0);
    chk({tag, " oor_a"},   32'(oor_a), 0);
    chk({tag, " perr_a"},  32'(perr_a), 0);
    chk({tag, " ready_b"}, 32'(ready_b), 0);
    chk({tag, " busy_b"},  32'(busy_b), 1);
  endtask

  // Counts edges until each instance leaves CLEAR; optional clr_start poke mid-clear.
  task automatic measure(input string tag, input bit poke);
    int ra = 0, ba = 0, rb = 0, bb = 0;
    for (int k = 1; k <= 1200; k++) begin
      if (poke && k == 300) clr_start = 1'b1;
      step();
      clr_start = 1'b0;
      if (ra == 0 && ready_a)  ra = k;
      if (ba == 0 && !busy_a)  ba = k;
      if (rb == 0 && ready_b)  rb = k;
      if (bb == 0 && !busy_b)  bb = k;
    end
    chk({tag, " ready_a edges"}, 32'(ra), 1024);
    chk({tag, " busy_a edges"},  32'(ba), 1024);
    chk({tag, " ready_b edges"}, 32'(rb), 1000);
    chk({tag, " busy_b edges"},  32'(bb), 1000);
  endtask

  task automatic read_zero(input string tag, input int addr, input bit oor_b_exp);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'(addr);
    step();
    req_valid = 1'b0;
    chk({tag, " valid_a"}, 32'(valid_a), 1);
    chk({tag, " rdata_a"}, 32'(rdata_a), 0);
    chk({tag, " valid_b"}, 32'(valid_b), 1);
    chk({tag, " rdata_b"}, 32'(rdata_b), 0);
    chk({tag, " oor_b"},   32'(oor_b), 32'(oor_b_exp));
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; clr_start = 1'b0; err_inj = 1'b0;
    req_addr = '0; req_wdata = '0;

    #2;
    chk_idle_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    measure("init clear", 1'b0);

    vecs.push_back(mk(0,    5, 0,     0, 12'h000, 0, 12'h000, 0, 0));
    vecs.push_back(mk(1,  999, 12'h777, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1023, 12'hABC, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1023, 0,     0, 12'hABC, 0, 12'h000, 1, 0));
    vecs.push_back(mk(1, 1000, 12'h123, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1000, 0,     0, 12'h123, 0, 12'h000, 1, 0));
    vecs.push_back(mk(0,  999, 0,     0, 12'h777, 0, 12'h777, 0, 0));
    vecs.push_back(mk(1,    1, 12'h111, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,    2, 12'h222, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,    3, 12'h333, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,    1, 0,     0, 12'h111, 0, 12'h111, 0, 0));
    vecs.push_back(mk(0,    2, 0,     0, 12'h222, 0, 12'h222, 0, 0));
    vecs.push_back(mk(0,    3, 0,     0, 12'h333, 0, 12'h333, 0, 0));
    vecs.push_back(mk(1,    4, 12'hFFF, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,    4, 0,     0, 12'hFFF, 0, 12'hFFF, 0, 0));
    vecs.push_back(mk(1,    7, 12'h555, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,    7, 0,     0, 12'h555, 0, 12'h555, 0, PAR_EN));
    vecs.push_back(mk(1,    7, 12'h555, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,    7, 0,     0, 12'h555, 0, 12'h555, 0, 0));
    vecs.push_back(mk(0, 1023, 0,     0, 12'hABC, 0, 12'h000, 1, 0));

    // One request per cycle; each response is sampled just after its accept edge.
    foreach (vecs[i]) begin
      req_valid = 1'b1; req_we = vecs[i].we; req_addr = vecs[i].addr;
      req_wdata = vecs[i].wdata; err_inj = vecs[i].err;
      step();
      if (vecs[i].we) begin
        chk($sformatf("vec%0d valid_a", i), 32'(valid_a), 0);
        chk($sformatf("vec%0d valid_b", i), 32'(valid_b), 0);
      end else begin
        chk($sformatf("vec%0d valid_a", i), 32'(valid_a), 1);
        chk($sformatf("vec%0d rdata_a", i), 32'(rdata_a), 32'(vecs[i].exp_a));
        chk($sformatf("vec%0d oor_a", i),   32'(oor_a),   32'(vecs[i].oor_a));
        chk($sformatf("vec%0d perr_a", i),  32'(perr_a),  32'(vecs[i].perr));
        chk($sformatf("vec%0d valid_b", i), 32'(valid_b), 1);
        chk($sformatf("vec%0d rdata_b", i), 32'(rdata_b), 32'(vecs[i].exp_b));
        chk($sformatf("vec%0d oor_b", i),   32'(oor_b),   32'(vecs[i].oor_b));
        chk($sformatf("vec%0d perr_b", i),  32'(perr_b),  32'(vecs[i].perr));
      end
    end
    req_valid = 1'b0; err_inj = 1'b0;

    step();
    chk("hold valid_a", 32'(valid_a), 0);
    chk("hold rdata_a", 32'(rdata_a), 12'hABC);
    chk("hold oor_a",   32'(oor_a), 0);
    chk("hold rdata_b", 32'(rdata_b), 0);
    chk("hold oor_b",   32'(oor_b), 0);

    // clr_start together with a read: read is accepted and returns pre-clear data.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd1; clr_start = 1'b1;
    step();
    req_valid = 1'b0; clr_start = 1'b0;
    chk("clr read valid_a", 32'(valid_a), 1);
    chk("clr read rdata_a", 32'(rdata_a), 12'h111);
    chk("clr read rdata_b", 32'(rdata_b), 12'h111);
    chk("clr ready_a",      32'(ready_a), 0);
    chk("clr busy_a",       32'(busy_a), 1);
    measure("clr_start clear", 1'b1);
    read_zero("post clr a1",    1,    1'b0);
    read_zero("post clr a999",  999,  1'b0);
    read_zero("post clr a1023", 1023, 1'b1);

    // Refill a word, start a clear, then reset in the middle of it.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd2; req_wdata = 12'h2A2;
    step();
    req_valid = 1'b0; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (500) step();
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid-clear reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    measure("restart clear", 1'b0);
    read_zero("post restart a2", 2, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ram_block.md
# ram_block

Parametrised single-port synchronous RAM with a valid/ready request port and a registered read response. It replaces the fixed 1024x12 tristate-bus memory, and data in and out use separate ports. A built-in clear engine zeroes every word after reset and on demand. Optional per-word parity reports corrupted reads. It sits between a bus master or datapath and on-chip storage.

## Interface
- DATA_W, 12, word width in bits (1..64)
- ADDR_W, 10, address width
- DEPTH, 1<<ADDR_W, number of words (2..2^ADDR_W, need not be a power of two)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle pulse, read data valid
- rsp_rdata  out  DATA_W  read data
- rsp_oor  out  1  qualifies rsp_valid: address was >= DEPTH
- rsp_perr  out  1  qualifies rsp_valid: parity mismatch (0 when parity compiled out)
- clr_start  in  1  request full clear
- clr_busy  out  1  clear engine active
- err_inj  in  1  with a write, store inverted parity (ignored when parity compiled out)

Clock is one domain, clk. Reset is rst_n, asynchronous assert, active-low.

## Operation
- FSM states: CLEAR and RUN.
- CLEAR:
  - Write 0, with correct parity, to word clr_ptr each cycle. clr_ptr counts 0..DEPTH-1.
  - req_ready=0 and clr_busy=1.
  - After the write of DEPTH-1, go to RUN.
- RUN:
  - req_ready=1 and clr_busy=0.
  - clr_start=1 goes to CLEAR with clr_ptr=0 on the next edge. req_ready drops in that same next cycle.
  - A request presented in the same cycle as clr_start is still accepted.
- Write accept: req_valid & req_ready & req_we. The word updates on that edge. No response is generated.
- Read accept: req_valid & req_ready & !req_we.
  - rsp_valid=1 on the following cycle, with rsp_rdata = stored word.
  - There is no response backpressure. Throughput is one request per cycle.
- Address >= DEPTH:
  - A write is dropped.
  - A read returns rsp_rdata=0 with rsp_oor=1 and rsp_perr=0.
- Read-after-write to the same address in consecutive cycles returns the new data. The write completes at edge N and the read samples at edge N+1.
- A read accepted in the cycle before entering CLEAR still produces its response.
- clr_start while already in CLEAR is ignored. The clear is not restarted.
- Reset assertion at any time, including mid-clear:
  - State goes to CLEAR, clr_ptr=0, and the clear restarts after release.
  - Memory contents are not reset directly.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_oor=0, rsp_perr=0, clr_busy=1.
- A clear takes exactly DEPTH cycles. req_ready rises in the cycle after the clear writes word DEPTH-1.
  - Cycle count starts from the first rising edge after rst_n deasserts.
  - Or from the edge that samples clr_start.
- Read latency is 1 cycle, from the accept edge to rsp_valid high.
- rsp_rdata holds its last value when rsp_valid=0.
- rsp_oor and rsp_perr are 0 when rsp_valid=0.

## Configuration
- RAM_PARITY_EN:
  - Defined:
    - The array is DATA_W+1 wide, with even parity in the MSB.
    - Written parity is ^req_wdata, inverted when err_inj=1.
    - On a read, rsp_perr=1 if recomputed parity differs from stored parity.
  - Undefined:
    - The array is DATA_W wide, rsp_perr is tied 0, and err_inj is unused.

## Structure
- Package ram_pkg contains:
  - state enum {CLEAR, RUN}
  - function parity(data)
  - localparam for the array word width, derived from RAM_PARITY_EN
- Sub-module ram_array is plain storage with one synchronous write port and one registered read port. It has no reset.
- ram_block holds the FSM, clear counter, range check, parity logic and response register.

## Test plan
- Reset with DEPTH=1024:
  - req_ready=0 and clr_busy=1 for exactly 1024 cycles after release, then req_ready=1.
  - A read of address 5 returns 0x000.
- Write 0xABC to address 0x3FF, then read 0x3FF on the next cycle:
  - rsp_valid one cycle later with rsp_rdata=0xABC, rsp_oor=0.
- DEPTH=1000, write 0x123 to address 1000, then read address 1000:
  - rsp_rdata=0, rsp_oor=1.
  - A read of address 999 still returns its prior value.
- Back-to-back reads of addresses 1,2,3 on consecutive cycles:
  - Three consecutive rsp_valid pulses with the matching data, no bubbles.
- clr_start after several writes, with a read accepted in the same cycle:
  - The read response returns the pre-clear data.
  - clr_busy=1 for DEPTH cycles, then all reads return 0.
  - Assert rst_n=0 mid-clear: the clear restarts from 0 and the full DEPTH cycles are required again.
- With RAM_PARITY_EN defined:
  - Write 0x555 with err_inj=1, then read: rsp_perr=1.
  - Rewrite with err_inj=0, then read: rsp_perr=0, data=0x555.
